// File: rtl/zet_div_pkg.sv
// Shared constants for the Zet DIV/IDIV sequencer: state encodings,
// iteration counts and signed quotient limits.
package zet_div_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int unsigned DIV_N_WORD = 16;
    localparam int unsigned DIV_N_BYTE = 8;
    localparam int unsigned CNT_W      = 5;

    localparam logic [15:0] QMAX_W = 16'h7FFF;
    localparam logic [15:0] QMAX_B = 16'h007F;

endpackage

// File: rtl/fulladd16.sv
// 16-bit adder primitive shared with the ALU; s enables the carry out.
module fulladd16 (
    input  logic [15:0] x_i,
    input  logic [15:0] y_i,
    input  logic        ci_i,
    input  logic        s_i,
    output logic        co_o,
    output logic [15:0] z_o
);

    logic [16:0] sum;

    // Plain 17-bit add; bit 16 is the carry.
    assign sum  = {1'b0, x_i} + {1'b0, y_i} + 17'(ci_i);
    assign z_o  = sum[15:0];
    assign co_o = s_i & sum[16];

endmodule

// File: rtl/zet_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module zet_div_step (
    input  logic [15:0] rem_i,
    input  logic        bit_i,
    input  logic [15:0] dvr_i,
    output logic [15:0] rem_o,
    output logic        qbit_o
);

    logic [15:0] shifted;
    logic [15:0] diff;
    logic        co;

    assign shifted = {rem_i[14:0], bit_i};

    fulladd16 u_add (
        .x_i  (shifted),
        .y_i  (~dvr_i),
        .ci_i (1'b1),
        .s_i  (1'b1),
        .co_o (co),
        .z_o  (diff)
    );

    // The bit shifted out of rem_i makes the partial remainder >= 2^16 > divisor,
    // so the subtraction always succeeds and the 16-bit difference is exact.
    assign qbit_o = rem_i[15] | co;
    assign rem_o  = qbit_o ? diff : shifted;

endmodule

// File: rtl/zet_div_seq.sv
// Multicycle 8086 DIV/IDIV unit (32/16 word, 16/8 byte, signed or unsigned).
// Optional macro ZET_DIV_186_RANGE_EN: also accept quotient -32768 / -128.
module zet_div_seq
    import zet_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic        byte_op,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quot,
    output logic [15:0] rem,
    output logic        div_exc
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      prem_q, prem_d;
    logic [15:0]      pdvd_q, pdvd_d;
    logic [15:0]      dvr_q, dvr_d;
    logic             byte_q, byte_d;
    logic             sgn_q, sgn_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [15:0]      quot_q, quot_d;
    logic [15:0]      rem_q, rem_d;
    logic             exc_q, exc_d;

    logic        dvd_neg, dvr_neg;
    logic [32:0] dvd_ext, dvd_mag;
    logic [16:0] dvr_ext, dvr_mag, hi_mag;
    logic        early_exc;
    logic [15:0] step_rem;
    logic        step_q;
    logic [15:0] lim, mask, quot_fix, rem_fix;
    logic        neg_edge, range_exc;

    // Operand magnitudes at launch; widened by one bit so the most negative value cannot wrap.
    assign dvd_neg   = sgn & (byte_op ? dividend[15] : dividend[31]);
    assign dvd_ext   = byte_op ? {{17{dvd_neg}}, dividend[15:0]} : {dvd_neg, dividend};
    assign dvd_mag   = dvd_neg ? 33'(-dvd_ext) : dvd_ext;
    assign dvr_neg   = sgn & (byte_op ? divisor[7] : divisor[15]);
    assign dvr_ext   = byte_op ? {{9{dvr_neg}}, divisor[7:0]} : {dvr_neg, divisor};
    assign dvr_mag   = dvr_neg ? 17'(-dvr_ext) : dvr_ext;
    assign hi_mag    = byte_op ? {8'h00, dvd_mag[16:8]} : dvd_mag[32:16];
    assign early_exc = (dvr_mag == 17'd0) | (hi_mag >= dvr_mag);

    zet_div_step u_step (
        .rem_i  (prem_q),
        .bit_i  (pdvd_q[15]),
        .dvr_i  (dvr_q),
        .rem_o  (step_rem),
        .qbit_o (step_q)
    );

    // Sign application and signed range check for the FIX cycle.
    assign lim  = byte_q ? QMAX_B : QMAX_W;
    assign mask = byte_q ? 16'h00FF : 16'hFFFF;
`ifdef ZET_DIV_186_RANGE_EN
    assign neg_edge = qneg_q & (pdvd_q == lim + 16'd1);
`else
    assign neg_edge = 1'b0;
`endif
    assign range_exc = sgn_q & (pdvd_q > lim) & ~neg_edge;
    assign quot_fix  = (qneg_q ? 16'(-pdvd_q) : pdvd_q) & mask;
    assign rem_fix   = (rneg_q ? 16'(-prem_q) : prem_q) & mask;

    // Next-state, datapath and output-register update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prem_d  = prem_q;
        pdvd_d  = pdvd_q;
        dvr_d   = dvr_q;
        byte_d  = byte_q;
        sgn_d   = sgn_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        exc_d   = exc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    quot_d = 16'h0000;
                    rem_d  = 16'h0000;
                    exc_d  = 1'b0;
                    byte_d = byte_op;
                    sgn_d  = sgn;
                    qneg_d = dvd_neg ^ dvr_neg;
                    rneg_d = dvd_neg;
                    dvr_d  = dvr_mag[15:0];
                    prem_d = byte_op ? {8'h00, dvd_mag[15:8]} : dvd_mag[31:16];
                    pdvd_d = byte_op ? {dvd_mag[7:0], 8'h00} : dvd_mag[15:0];
                    cnt_d  = byte_op ? CNT_W'(DIV_N_BYTE) : CNT_W'(DIV_N_WORD);
                    if (early_exc) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                prem_d = step_rem;
                pdvd_d = {pdvd_q[14:0], step_q};
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_DONE;
                done_d  = 1'b1;
                if (range_exc) begin
                    exc_d = 1'b1;
                end else begin
                    quot_d = quot_fix;
                    rem_d  = rem_fix;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and register bank with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prem_q  <= '0;
            pdvd_q  <= '0;
            dvr_q   <= '0;
            byte_q  <= 1'b0;
            sgn_q   <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prem_q  <= prem_d;
            pdvd_q  <= pdvd_d;
            dvr_q   <= dvr_d;
            byte_q  <= byte_d;
            sgn_q   <= sgn_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            exc_q   <= exc_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign quot    = quot_q;
    assign rem     = rem_q;
    assign div_exc = exc_q;

endmodule

// File: tb/tb_zet_div_seq.sv
// Bench for zet_div_seq: arithmetic reference model plus per-cycle compare.
module tb_zet_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sgn;
    logic        byte_op;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quot;
    logic [15:0] rem;
    logic        div_exc;

    zet_div_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sgn      (sgn),
        .byte_op  (byte_op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .div_exc  (div_exc)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference: plain x86 integer division semantics.
    function automatic void model(input bit sg, input bit bt, input logic [31:0] dd,
                                  input logic [15:0] dv, output logic [15:0] q,
                                  output logic [15:0] r, output bit x, output int lat);
        longint a, b, qq, rr, ma, mb, hi, lim;
        if (bt) begin
            a = sg ? longint'($signed(dd[15:0])) : longint'({48'h0, dd[15:0]});
            b = sg ? longint'($signed(dv[7:0]))  : longint'({56'h0, dv[7:0]});
        end else begin
            a = sg ? longint'($signed(dd)) : longint'({32'h0, dd});
            b = sg ? longint'($signed(dv)) : longint'({48'h0, dv});
        end
        ma = (a < 0) ? -a : a;
        mb = (b < 0) ? -b : b;
        hi = bt ? (ma >> 8) : (ma >> 16);
        q = 16'h0; r = 16'h0;
        if (mb == 0 || hi >= mb) begin
            x = 1'b1; lat = 1;
            return;
        end
        lat = bt ? 10 : 18;
        qq  = a / b;
        rr  = a % b;
        lim = bt ? 127 : 32767;
`ifdef ZET_DIV_186_RANGE_EN
        x = sg && (qq > lim || qq < -lim - 1);
`else
        x = sg && (qq > lim || qq < -lim);
`endif
        if (!x) begin
            q = bt ? {8'h00, qq[7:0]} : qq[15:0];
            r = bt ? {8'h00, rr[7:0]} : rr[15:0];
        end
    endfunction

    // Expected timeline of the current operation and held results.
    bit          active = 1'b0;
    int          rel = 0;
    int          e_lat = 0;
    logic [15:0] e_q = '0, e_r = '0, h_q = '0, h_r = '0;
    bit          e_x = 1'b0, h_x = 1'b0;

    // Per-cycle compare of all outputs against the expected timeline.
    always @(negedge clk) begin
        if (active) begin
            chk("busy", 32'(busy), 32'(rel >= 1 && rel <= e_lat));
            chk("done", 32'(done), 32'(rel == e_lat));
            if (rel == e_lat) begin
                chk("quot", 32'(quot), 32'(e_q));
                chk("rem", 32'(rem), 32'(e_r));
                chk("div_exc", 32'(div_exc), 32'(e_x));
                h_q = e_q; h_r = e_r; h_x = e_x;
                active = 1'b0;
            end else if (rel == 0) begin
                chk("quot_hold", 32'(quot), 32'(h_q));
                chk("rem_hold", 32'(rem), 32'(h_r));
                chk("exc_hold", 32'(div_exc), 32'(h_x));
            end else begin
                chk("quot_clr", 32'(quot), 32'h0);
                chk("rem_clr", 32'(rem), 32'h0);
                chk("exc_clr", 32'(div_exc), 32'h0);
            end
            rel++;
        end else begin
            chk("idle_busy", 32'(busy), 32'h0);
            chk("idle_done", 32'(done), 32'h0);
            chk("idle_quot", 32'(quot), 32'(h_q));
            chk("idle_rem", 32'(rem), 32'(h_r));
            chk("idle_exc", 32'(div_exc), 32'(h_x));
        end
    end

    typedef struct {
        bit          sg;
        bit          bt;
        logic [31:0] dd;
        logic [15:0] dv;
        logic [15:0] q;
        logic [15:0] r;
        bit          x;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    // Launch one operation after pinning the model to the hand-computed answer.
    task automatic launch(input vec_t v);
        logic [15:0] mq, mr;
        bit          mx;
        int          ml;
        model(v.sg, v.bt, v.dd, v.dv, mq, mr, mx, ml);
        chk("model_q", 32'(mq), 32'(v.q));
        chk("model_r", 32'(mr), 32'(v.r));
        chk("model_x", 32'(mx), 32'(v.x));
        chk("model_lat", 32'(ml), 32'(v.lat));
        @(posedge clk); #1;
        sgn = v.sg; byte_op = v.bt; dividend = v.dd; divisor = v.dv; start = 1'b1;
        e_q = mq; e_r = mr; e_x = mx; e_lat = ml; rel = 0; active = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_op(input vec_t v, input bit poke);
        launch(v);
        if (poke) begin
            // A start while busy must be ignored and must not disturb captured operands.
            @(posedge clk); #1;
            start = 1'b1; dividend = 32'h0; divisor = 16'h0; sgn = ~v.sg;
            @(posedge clk); #1;
            start = 1'b0;
        end
        for (int g = 0; g < 40 && active; g++) @(posedge clk);
        if (active) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: done not seen, expected at cycle %0d", e_lat);
            active = 1'b0;
        end
        @(posedge clk);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 32'h0001_0000, 16'h0003, 16'h5555, 16'h0001, 1'b0, 18};
        vecs[1]  = '{1'b0, 1'b0, 32'h1234_5678, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1};
        vecs[2]  = '{1'b1, 1'b1, 32'h0000_1234, 16'h0100, 16'h0000, 16'h0000, 1'b1, 1};
        vecs[3]  = '{1'b0, 1'b0, 32'h0003_0000, 16'h0002, 16'h0000, 16'h0000, 1'b1, 1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0001_7FFF, 16'h0002, 16'hBFFF, 16'h0001, 1'b0, 18};
        vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 18};
`ifdef ZET_DIV_186_RANGE_EN
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_FF00, 16'h0002, 16'h0080, 16'h0000, 1'b0, 10};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 18};
`else
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_FF00, 16'h0002, 16'h0000, 16'h0000, 1'b1, 10};
        vecs[9]  = '{1'b1, 1'b0, 32'hFFFF_8000, 16'h0001, 16'h0000, 16'h0000, 1'b1, 18};
`endif
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 10};
        vecs[8]  = '{1'b1, 1'b0, 32'h8000_0000, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 18};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_FF9C, 16'h0007, 16'h00F2, 16'h00FE, 1'b0, 10};
        vecs[12] = '{1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 18};
        vecs[13] = '{1'b0, 1'b1, 32'hABCD_00FF, 16'hFF10, 16'h000F, 16'h000F, 1'b0, 10};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_4000, 16'h8000, 16'h0000, 16'h4000, 1'b0, 18};

        rst = 1'b1; start = 1'b0; sgn = 1'b0; byte_op = 1'b0;
        dividend = 32'h0; divisor = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);

        for (int i = 0; i < 15; i++) run_op(vecs[i], i == 0);

        // Reset in cycle 5 of a word divide: immediate clear, no done pulse.
        launch(vecs[0]);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        active = 1'b0; h_q = 16'h0; h_r = 16'h0; h_x = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (25) @(posedge clk);
        run_op(vecs[7], 1'b0);

        // Start coinciding with reset is dropped.
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1; sgn = 1'b0; byte_op = 1'b0;
        dividend = 32'h0001_0000; divisor = 16'h0003;
        h_q = 16'h0; h_r = 16'h0; h_x = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (22) @(posedge clk);
        run_op(vecs[5], 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
